// File: rtl/fetch_seq16_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding,
// default datapath width and the PC register's reset value.
package fetch_seq16_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  localparam int          WIDTH_DEFAULT = 16;
  localparam logic [15:0] PC_RESET      = 16'h0100;

endpackage

// File: rtl/fetch_wait_timer.sv
// Counts unacknowledged FETCH cycles and flags the cycle on which the
// count would reach MAX_WAIT, so the timeout lands on that same edge.
module fetch_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign expired = en && (count == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/fetch_seq16.sv
// Instruction-fetch sequencer: fetches at PC over req/ack, latches the word
// into IR, hands it to decode over valid/ready and steers the PC register.
module fetch_seq16
  import fetch_seq16_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEFAULT,
  parameter int INC      = 1,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next,
  output logic             pc_load,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_data,
  output logic [WIDTH-1:0] ir,
  output logic             ir_valid,
  input  logic             ir_ready,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_addr,
  input  logic             halt,
  output logic             fetch_err
);

  fetch_state_t     state;
  logic             pend_valid;
  logic [WIDTH-1:0] pend_addr;
  logic             timer_en;
  logic             timer_clr;
  logic             expired;

  assign timer_en  = (state == FETCH) && !imem_ack;
  assign timer_clr = (state != FETCH) || imem_ack;

  fetch_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .en     (timer_en),
    .clr    (timer_clr),
    .expired(expired)
  );

  assign imem_addr = pc;

  // A redirect arriving with the ack is newer than any pending target.
  always_comb begin
    pc_load  = 1'b0;
    pc_next  = pc;
    imem_req = 1'b0;
    case (state)
      IDLE, HOLD: begin
        if (redirect) begin
          pc_load = 1'b1;
          pc_next = redirect_addr;
        end
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          pc_load = 1'b1;
          if (redirect)        pc_next = redirect_addr;
          else if (pend_valid) pc_next = pend_addr;
          else                 pc_next = pc + WIDTH'(INC);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ir         <= '0;
      ir_valid   <= 1'b0;
      fetch_err  <= 1'b0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
    end else begin
      case (state)
        IDLE: state <= halt ? HALTED : FETCH;
        FETCH: begin
          if (imem_ack) begin
            pend_valid <= 1'b0;
            if (!(redirect || pend_valid)) begin
              ir       <= imem_data;
              ir_valid <= 1'b1;
              state    <= HOLD;
            end
          end else if (expired) begin
            fetch_err  <= 1'b1;
            pend_valid <= 1'b0;
            state      <= HALTED;
          end else if (redirect) begin
            pend_valid <= 1'b1;
            pend_addr  <= redirect_addr;
          end
        end
        // A squashing redirect wins over a same-cycle decode handshake.
        HOLD: begin
          if (redirect) begin
            ir_valid <= 1'b0;
            state    <= FETCH;
          end else if (ir_ready) begin
            ir_valid <= 1'b0;
            state    <= halt ? HALTED : FETCH;
          end
        end
        default: ir_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: doc/fetch_seq16.md
# fetch_seq16

Instruction-fetch sequencer placed directly upstream of the 16-bit program-counter register, which resets to 0x0100. The sequencer reads the current PC, runs a req/ack fetch against instruction memory and latches the returned word into an instruction register. It hands that word to decode over a valid/ready handshake. It also drives the PC register's `IN`/`LOAD` pair for sequential increment and for branch/jump redirects.

## Interface
Parameters:
- `WIDTH`, 16: address/data width.
- `INC`, 1: PC increment per fetched instruction.
- `MAX_WAIT`, 15: maximum FETCH cycles without `IMEM_ACK` before a fetch error.

Ports:
- `CLK`  in  1  sole clock, rising edge.
- `RESET`  in  1  synchronous, active-high.
- `PC`  in  WIDTH  current PC, from the PC register output.
- `PC_NEXT`  out  WIDTH  value to the PC register `IN`.
- `PC_LOAD`  out  1  load strobe to the PC register.
- `IMEM_REQ`  out  1  fetch request.
- `IMEM_ADDR`  out  WIDTH  fetch address, equal to `PC` while `IMEM_REQ` is high.
- `IMEM_ACK`  in  1  memory has returned data this cycle.
- `IMEM_DATA`  in  WIDTH  instruction word, valid with `IMEM_ACK`.
- `IR`  out  WIDTH  latched instruction.
- `IR_VALID`  out  1  `IR` holds an unconsumed instruction.
- `IR_READY`  in  1  decode accepts `IR` this cycle.
- `REDIRECT`  in  1  branch/jump taken.
- `REDIRECT_ADDR`  in  WIDTH  target address.
- `HALT`  in  1  stop fetching at the next boundary.
- `FETCH_ERR`  out  1  sticky timeout flag.

## Operation
- States: IDLE, FETCH, HOLD, HALTED.
- Reset values: state = IDLE, `IR` = 0, `IR_VALID` = 0, `FETCH_ERR` = 0, wait counter = 0, pending-redirect = 0. Consequently `IMEM_REQ` = 0 and `PC_LOAD` = 0.
- **IDLE:**
  - Go to HALTED if `HALT`, otherwise to FETCH.
  - If `REDIRECT` is high: `PC_LOAD` = 1 and `PC_NEXT` = `REDIRECT_ADDR`.
- **FETCH:**
  - `IMEM_REQ` = 1 and `IMEM_ADDR` = `PC`.
  - Once raised, `IMEM_REQ` stays high until `IMEM_ACK` or timeout.
  - A `REDIRECT` seen in FETCH is captured as a pending target. The newest target overwrites any older one.
  - On `IMEM_ACK` with no pending redirect and no `REDIRECT` this cycle:
    - `IR` <= `IMEM_DATA`.
    - `PC_LOAD` = 1 and `PC_NEXT` = (`PC` + `INC`) mod 2^WIDTH.
    - Next state is HOLD.
  - On `IMEM_ACK` with a redirect (pending or current):
    - The data is discarded and `IR_VALID` stays 0.
    - `PC_LOAD` = 1 with the target.
    - The pending target is cleared and the state stays FETCH.
  - Wait counter:
    - Increments each FETCH cycle without ack and clears on ack.
    - When it reaches `MAX_WAIT`: `FETCH_ERR` <= 1, `IMEM_REQ` drops, next state is HALTED.
- **HOLD:**
  - `IR_VALID` = 1 and `IR` is stable.
  - `REDIRECT` has priority over `IR_READY`:
    - `IR_VALID` is cleared (squash) and the handshake does not count.
    - `PC_LOAD` = 1 with `REDIRECT_ADDR`.
    - Next state is FETCH.
  - Else if `IR_READY`: next state is HALTED if `HALT`, otherwise FETCH.
- **HALTED:**
  - No requests; `REDIRECT` and `HALT` are ignored.
  - `IR_VALID` = 0.
  - Left only by `RESET`.
- `HALT` asserted during FETCH does not abort the fetch. It is taken at the HOLD exit.
- `PC_LOAD` is 0 in all cases other than those listed above.

## Timing
- `PC_LOAD`, `PC_NEXT`, `IMEM_REQ` and `IMEM_ADDR` are combinational from state and inputs. The PC register therefore updates on the same edge that captures `IR`.
- `IR`, `IR_VALID` and `FETCH_ERR` are registered.
- First cycle after reset is released: IDLE. Next cycle: FETCH at `IMEM_ADDR` = 0x0100.
- With zero-wait memory, `IMEM_ACK` arrives in the FETCH cycle. `IR_VALID` rises the following cycle.
- Peak throughput is one instruction per 2 cycles: a FETCH cycle plus a HOLD cycle, with `IR_READY` held high.
- `RESET` mid-fetch:
  - Abandons the transaction; `IMEM_REQ` is 0 in the cycle after the reset edge.
  - A late `IMEM_ACK` is ignored outside FETCH.
- `FETCH_ERR` rises on the edge after the `MAX_WAIT`-th unacknowledged FETCH cycle.

## Structure
- Shared package/header holds:
  - State encoding: IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2, HALTED = 2'd3.
  - `WIDTH` default.
  - PC reset constant 0x0100, for the bench.
- One sub-module, `fetch_wait_timer`:
  - Inputs: `CLK`, `RESET`, `EN`, `CLR`.
  - Output: `EXPIRED`, high when the count reaches `MAX_WAIT`.
  - Counter width is ceil(log2(`MAX_WAIT`+1)).

## Test plan
- Reset, zero-wait memory returning 0x1234:
  - Cycle 1: `IMEM_ADDR` = 0x0100, `PC_LOAD` = 1, `PC_NEXT` = 0x0101.
  - Cycle 2: `IR` = 0x1234, `IR_VALID` = 1.
- Backpressure, `IR_READY` low for 5 cycles → `IR_VALID` stays 1, `IR` unchanged, `IMEM_REQ` = 0; the next fetch goes out 1 cycle after `IR_READY` rises.
- 3 wait states, `REDIRECT` to 0x2000 in wait cycle 1 → `IMEM_REQ` held until ack, data discarded, no `IR_VALID`, `PC_LOAD` with 0x2000 on ack, next `IMEM_ADDR` = 0x2000.
- `MAX_WAIT` = 4 with no ack → `FETCH_ERR` = 1 after 4 FETCH cycles, `IMEM_REQ` = 0, no further activity until `RESET`; `RESET` clears `FETCH_ERR`.
- `PC` = 0xFFFF with ack → `PC_NEXT` = 0x0000; `REDIRECT` and `IR_READY` together in HOLD → squash, `IR_VALID` = 0, fetch at `REDIRECT_ADDR`.
- `RESET` pulsed during wait cycle 2 → next cycle all outputs at reset values; fetch restarts at 0x0100 two cycles later.
